// File: rtl/sigma_delta_adc_scheduler_pkg.sv
// Shared types and width helpers for the multiplexed sigma-delta ADC scheduler.
package sigma_delta_pkg;

    typedef enum logic [2:0] {IDLE, SELECT, SETTLE, DROP, KEEP} sd_sched_state_t;

    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Counter that must hold 0..max; never narrower than one bit.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/sigma_delta_adc_scheduler_if.sv
// Tagged sample stream from the scheduler to its consumer (valid/ready).
interface sigma_delta_adc_scheduler_if #(
    parameter int WDTH = 16,
    parameter int CHW  = 2
);
    logic signed [WDTH-1:0] out_data;
    logic [CHW-1:0]         out_ch;
    logic                   out_valid;
    logic                   out_ready;

    modport master (output out_data, output out_ch, output out_valid, input out_ready);
    modport slave  (input out_data, input out_ch, input out_valid, output out_ready);
endinterface

// File: rtl/sigma_delta_adc_scheduler_rr_pick.sv
// Combinational round-robin picker: lowest enabled index strictly after ptr, wrapping.
module sd_rr_pick #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic [NCH-1:0] enable,
    input  logic [CHW-1:0] ptr,
    output logic [CHW-1:0] next_idx,
    output logic           any_enabled
);
    int   cand;
    logic found;

    always_comb begin
        next_idx    = '0;
        any_enabled = |enable;
        found       = 1'b0;
        cand        = 0;
        for (int i = 1; i <= NCH; i++) begin
            cand = (int'(ptr) + i) % NCH;
            if (!found && enable[cand]) begin
                next_idx = cand[CHW-1:0];
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sigma_delta_adc_scheduler.sv
// Round-robin channel scheduler for one shared sigma-delta ADC behind an analog mux.
// Optional per-visit averaging is enabled with `define SD_SCHED_AVG_EN.
module sigma_delta_adc_scheduler
    import sigma_delta_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int WDTH      = 16,
    parameter int FLUSH_CYC = 64,
    parameter int DISCARD   = 2,
    parameter int DWELL     = 4,
    localparam int CHW      = ch_width(NCH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         ch_enable,
    input  logic                   run,
    input  logic signed [WDTH-1:0] adc_s_sample,
    input  logic                   adc_valid,
    output logic [CHW-1:0]         mux_sel,
    output logic                   adc_flush,
    sigma_delta_adc_scheduler_if.master stream,
    output logic                   busy,
    output logic                   overrun
);
    localparam int SW = $clog2(FLUSH_CYC + 1);
    localparam int DW = cnt_width(DISCARD);
    localparam int KW = cnt_width(DWELL);

    sd_sched_state_t state, state_nxt;
    logic [CHW-1:0]  ptr;
    logic [CHW-1:0]  pick_idx;
    logic            pick_any;
    logic [SW-1:0]   settle_cnt;
    logic [DW-1:0]   drop_cnt;
    logic [KW-1:0]   keep_cnt;
    logic            kept, last_kept;
    logic            load;
    logic signed [WDTH-1:0] load_data;
    logic signed [WDTH-1:0] data_p1;
    logic [CHW-1:0]         ch_p1;
    logic                   vld_p1;

    sd_rr_pick #(.NCH(NCH), .CHW(CHW)) u_pick (
        .enable      (ch_enable),
        .ptr         (ptr),
        .next_idx    (pick_idx),
        .any_enabled (pick_any)
    );

    assign kept      = (state == KEEP) && adc_valid;
    assign last_kept = kept && (int'(keep_cnt) == DWELL - 1);
    assign adc_flush = (state == SETTLE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run && pick_any) state_nxt = SELECT;
            SELECT:  state_nxt = pick_any ? SETTLE : IDLE;
            SETTLE:  if (int'(settle_cnt) == FLUSH_CYC - 1)
                         state_nxt = (DISCARD == 0) ? KEEP : DROP;
            DROP:    if (adc_valid && int'(drop_cnt) == DISCARD - 1) state_nxt = KEEP;
            KEEP:    if (last_kept) state_nxt = run ? SELECT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= CHW'(NCH - 1);
            mux_sel    <= '0;
            settle_cnt <= '0;
            drop_cnt   <= '0;
            keep_cnt   <= '0;
        end else begin
            state <= state_nxt;
            // The mux only moves here, so it is stable for the whole visit.
            if (state == SELECT && pick_any) begin
                mux_sel <= pick_idx;
                ptr     <= pick_idx;
            end
            settle_cnt <= (state == SETTLE) ? settle_cnt + SW'(1) : '0;
            if (state == DROP) begin
                if (adc_valid) drop_cnt <= drop_cnt + DW'(1);
            end else begin
                drop_cnt <= '0;
            end
            if (state == KEEP) begin
                if (adc_valid) keep_cnt <= keep_cnt + KW'(1);
            end else begin
                keep_cnt <= '0;
            end
        end
    end

`ifdef SD_SCHED_AVG_EN
    localparam int LOG_DW = $clog2(DWELL);
    localparam int AW     = WDTH + LOG_DW;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sample_ext;
    logic signed [AW-1:0] acc_sum;

    function automatic logic signed [WDTH-1:0] avg_shift(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> LOG_DW;
        return s[WDTH-1:0];
    endfunction

    assign sample_ext = AW'(adc_s_sample);
    assign acc_sum    = acc + sample_ext;
    assign load       = last_kept;
    assign load_data  = avg_shift(acc_sum);

    always_ff @(posedge clk) begin
        if (state != KEEP && state_nxt == KEEP) acc <= '0;
        else if (kept)                          acc <= acc_sum;
    end
`else
    assign load      = kept;
    assign load_data = adc_s_sample;
`endif

    // Output stage: single register, a new load always wins over a drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_p1 <= '0;
            ch_p1   <= '0;
            vld_p1  <= 1'b0;
            overrun <= 1'b0;
        end else if (load) begin
            data_p1 <= load_data;
            ch_p1   <= mux_sel;
            vld_p1  <= 1'b1;
            if (vld_p1 && !stream.out_ready) overrun <= 1'b1;
        end else if (vld_p1 && stream.out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign stream.out_data  = data_p1;
    assign stream.out_ch    = ch_p1;
    assign stream.out_valid = vld_p1;
endmodule
